// File: rtl/tl_cmd_arbiter.sv
// tl_cmd_arbiter: shares the traffic_lights command port between requester A
// (local console) and requester B (remote link). Round-robin grant, legality
// filter, minimum spacing between forwarded commands, saturating issue count.
module tl_cmd_arbiter #(
  parameter int          CMD_GAP  = 2,
  parameter logic [15:0] MAX_TIME = 16'd60000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [2:0]       a_type_i,
  input  logic [15:0]      a_data_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [2:0]       b_type_i,
  input  logic [15:0]      b_data_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  output logic [2:0]       cmd_type_o,
  output logic [15:0]      cmd_data_o,
  output logic             cmd_valid_o,
  output logic             err_o,
  output logic             err_src_o,
  output logic [CNT_W-1:0] issued_cnt_o
);

  // gap counter only needs to hold CMD_GAP; keep at least one bit for CMD_GAP=0
  localparam int GAP_W = (CMD_GAP < 2) ? 1 : $clog2(CMD_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CMD_GAP);

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] data;
  } cmd_t;

  logic [GAP_W-1:0] gap_cnt;
  logic             rr_last_b;   // 1: B was granted last, so A wins the next tie
  logic             idle, grant_a, grant_b, xfer, legal;
  cmd_t             sel;

  // grant, mux of the winning command and legality check
  always_comb begin
    idle    = (gap_cnt == '0);
    grant_a = idle & a_valid_i & (~b_valid_i | rr_last_b);
    grant_b = idle & b_valid_i & (~a_valid_i | ~rr_last_b);
    xfer    = grant_a | grant_b;
    sel     = grant_b ? cmd_t'{b_type_i, b_data_i} : cmd_t'{a_type_i, a_data_i};
    // timing commands (3..5) need a non-zero duration within MAX_TIME;
    // data is don't-care for the on/off/uncontrolled commands
    legal   = (sel.typ <= 3'd5) &&
              ((sel.typ < 3'd3) || ((sel.data != 16'd0) && (sel.data <= MAX_TIME)));
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;

  // output strobe, error flag, RR pointer, spacing counter and issue count
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cmd_valid_o  <= 1'b0;
      cmd_type_o   <= '0;
      cmd_data_o   <= '0;
      err_o        <= 1'b0;
      err_src_o    <= 1'b0;
      rr_last_b    <= 1'b1;
      gap_cnt      <= '0;
      issued_cnt_o <= '0;
    end else begin
      cmd_valid_o <= xfer & legal;
      cmd_type_o  <= (xfer & legal) ? sel.typ  : 3'd0;
      cmd_data_o  <= (xfer & legal) ? sel.data : 16'd0;
      err_o       <= xfer & ~legal;
      if (xfer & ~legal)
        err_src_o <= grant_b;
      if (xfer)
        rr_last_b <= grant_b;
      // dropped commands do not consume a gap; only forwarded ones do
      if (xfer & legal) begin
        gap_cnt <= GAP_LOAD;
        if (issued_cnt_o != '1)
          issued_cnt_o <= issued_cnt_o + CNT_W'(1);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

endmodule
